reg_file_mp: RTL and testbench
==============================

Name: reg_file_mp

Overview:
Parametrised multi-port register file for the pipelined core. Provides NUM_READ asynchronous read ports, two synchronous write ports and optional write-to-read bypass. A per-register busy scoreboard supports hazard detection: the decode stage allocates a destination, writeback clears it. Register 0 is hardwired to zero, and a0 (x10) is exported for the testbench and display.

Parameters:
DATA_WIDTH, 32, register width in bits
ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH
NUM_READ, 2, number of read ports (1..4)
BYPASS, 1, 1 = read ports return same-cycle write data; 0 = read the stored value only
A0_INDEX, 10, register index driven onto a0

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous reset, active-low (asserted when 0)
rd_addr  input  NUM_READ*ADDR_WIDTH  read addresses; port i = bits [i*ADDR_WIDTH +: ADDR_WIDTH]
rd_data  output  NUM_READ*DATA_WIDTH  read data, packed the same way
rd_busy  output  NUM_READ  busy flag of each addressed register
we0  input  1  write enable, port 0 (low priority)
waddr0  input  ADDR_WIDTH  write address, port 0
wdata0  input  DATA_WIDTH  write data, port 0
we1  input  1  write enable, port 1 (high priority)
waddr1  input  ADDR_WIDTH  write address, port 1
wdata1  input  DATA_WIDTH  write data, port 1
alloc_en  input  1  mark alloc_addr busy (destination issued)
alloc_addr  input  ADDR_WIDTH  register being allocated
busy_count  output  ADDR_WIDTH+1  number of busy registers
a0  output  DATA_WIDTH  contents of register A0_INDEX (stored value, no bypass)

Behaviour:
- Reset (reset=0, asynchronous): all registers = 0, all busy bits = 0.
  - While reset is asserted: rd_data = 0, rd_busy = 0, busy_count = 0, a0 = 0, whatever the inputs.
  - Writes and allocs are ignored.
  - Deassertion takes effect at the next rising clk edge.
- Writes: synchronous on the rising edge.
  - Port k writes when wek=1 and waddrk != 0.
  - If both ports target the same nonzero address, port 1's data is stored.
- Register 0: always reads 0. It is never written, never busy, and an alloc to it is ignored.
- Reads: combinational, zero latency.
  - BYPASS=1: if we1 && waddr1==rd_addr_i && rd_addr_i!=0, return wdata1. Otherwise, if the same test holds for port 0, return wdata0. Otherwise return the stored value.
  - BYPASS=0: return the stored value; new data is visible the cycle after the write.
- Scoreboard: one busy bit per register, updated on the rising edge.
  - Set: alloc_en=1 and alloc_addr!=0.
  - Clear: a write by either port to that address (wek=1, waddrk!=0).
  - Alloc and write to the same address in the same cycle: alloc wins, so the bit stays/becomes 1 (new producer supersedes).
  - Alloc of an already-busy register: the bit stays 1 (no counting).
  - Write to a non-busy register: the data is stored, the bit stays 0.
- rd_busy_i: the current busy bit of rd_addr_i. When BYPASS=1, it is forced to 0 if the read is satisfied by the bypass that cycle and that write does not coincide with an alloc to the same address.
- busy_count: registered population count of the busy bits, updated in the same cycle as the bits; range 0..2**ADDR_WIDTH-1.
- a0: the stored register A0_INDEX, updated the cycle after a write.
- Out-of-range parameters (NUM_READ<1 or >4): elaboration error via generate-time assertion.

Test Plan:
- Reset: hold reset=0, drive we0=1 waddr0=5 wdata0=0xFFFF_FFFF -> rd_data all 0, busy_count=0; after release, read x5 -> 0.
- Dual write collision: we0=we1=1, waddr0=waddr1=7, wdata0=0x1111_1111, wdata1=0x2222_2222; next cycle, BYPASS=0, read x7 -> 0x2222_2222.
- Bypass: BYPASS=1, we0=1 waddr0=3 wdata0=0xDEAD_BEEF, rd_addr0=3 in the same cycle -> rd_data0=0xDEAD_BEEF combinationally; with BYPASS=0 -> old value 0.
- x0: we1=1 waddr1=0 wdata1=0x55; alloc_en=1 alloc_addr=0 -> reading x0 gives 0, rd_busy=0, busy_count unchanged.
- Scoreboard: alloc x10 -> busy_count=1, rd_busy=1 for x10. Writeback x10=0x42 -> busy cleared, a0=0x42 one cycle later. Alloc and write x10 in the same cycle -> busy stays 1.
- Async reset mid-operation: with 3 registers busy and data stored, pull reset low between clock edges -> busy_count and a0 go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/reg_file_mp.sv
// Multi-port register file with two write ports, optional write bypass
// and a per-register busy scoreboard for hazard detection.
module reg_file_mp #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_READ   = 2,
    parameter int BYPASS     = 1,
    parameter int A0_INDEX   = 10
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_READ*DATA_WIDTH-1:0] rd_data,
    output logic [NUM_READ-1:0]            rd_busy,
    input  logic                           we0,
    input  logic [ADDR_WIDTH-1:0]          waddr0,
    input  logic [DATA_WIDTH-1:0]          wdata0,
    input  logic                           we1,
    input  logic [ADDR_WIDTH-1:0]          waddr1,
    input  logic [DATA_WIDTH-1:0]          wdata1,
    input  logic                           alloc_en,
    input  logic [ADDR_WIDTH-1:0]          alloc_addr,
    output logic [ADDR_WIDTH:0]            busy_count,
    output logic [DATA_WIDTH-1:0]          a0
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    if (NUM_READ < 1 || NUM_READ > 4) begin : g_bad_num_read
        $error("reg_file_mp: NUM_READ must be in 1..4");
    end

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DATA_WIDTH-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]      busy_q;
    logic [DEPTH-1:0]      busy_d;
    logic [ADDR_WIDTH:0]   cnt_q;
    logic [ADDR_WIDTH:0]   cnt_d;

    logic wr0_en;
    logic wr1_en;
    logic al_en;

    assign wr0_en = we0 && (waddr0 != '0);
    assign wr1_en = we1 && (waddr1 != '0);
    assign al_en  = alloc_en && (alloc_addr != '0);

    // Port 1 is applied last so it wins an address collision.
    always_comb begin
        regs_d = regs_q;
        if (wr0_en) regs_d[waddr0] = wdata0;
        if (wr1_en) regs_d[waddr1] = wdata1;
    end

    // A new producer supersedes a retiring one on the same register.
    always_comb begin
        busy_d = busy_q;
        if (wr0_en) busy_d[waddr0] = 1'b0;
        if (wr1_en) busy_d[waddr1] = 1'b0;
        if (al_en) busy_d[alloc_addr] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_comb begin
        cnt_d = '0;
        for (int j = 0; j < DEPTH; j++) begin
            cnt_d = cnt_d + {{ADDR_WIDTH{1'b0}}, busy_d[j]};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int j = 0; j < DEPTH; j++) begin
                regs_q[j] <= '0;
            end
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy_count = cnt_q;
    assign a0         = regs_q[A0_INDEX];

    for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
        logic [ADDR_WIDTH-1:0] ra;
        logic                  hit0;
        logic                  hit1;
        logic                  al_hit;
        logic [DATA_WIDTH-1:0] val;
        logic                  bsy;

        assign ra     = rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign hit1   = (BYPASS != 0) && wr1_en && (waddr1 == ra);
        assign hit0   = (BYPASS != 0) && wr0_en && (waddr0 == ra);
        assign al_hit = al_en && (alloc_addr == ra);

        always_comb begin
            val = regs_q[ra];
            if (hit1) begin
                val = wdata1;
            end else if (hit0) begin
                val = wdata0;
            end
            bsy = busy_q[ra];
            if ((hit0 || hit1) && !al_hit) bsy = 1'b0;
        end

        // Outputs are forced quiet while reset is held, bypass included.
        assign rd_data[i*DATA_WIDTH +: DATA_WIDTH] = reset ? val : '0;
        assign rd_busy[i] = reset & bsy;
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: bypass and non-bypass instances
// driven in lockstep from a vector table plus reset sequences.
module tb_reg_file_mp;

    logic        clk;
    logic        reset;
    logic [9:0]  rd_addr;
    logic        we0, we1, alloc_en;
    logic [4:0]  waddr0, waddr1, alloc_addr;
    logic [31:0] wdata0, wdata1;

    logic [63:0] rd_data_b, rd_data_n;
    logic [1:0]  rd_busy_b, rd_busy_n;
    logic [5:0]  cnt_b, cnt_n;
    logic [31:0] a0_b, a0_n;

    int n_pass = 0;
    int n_total = 0;

    reg_file_mp #(.BYPASS(1)) u_byp (
        .clk(clk), .reset(reset), .rd_addr(rd_addr),
        .rd_data(rd_data_b), .rd_busy(rd_busy_b),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr),
        .busy_count(cnt_b), .a0(a0_b)
    );

    reg_file_mp #(.BYPASS(0)) u_nb (
        .clk(clk), .reset(reset), .rd_addr(rd_addr),
        .rd_data(rd_data_n), .rd_busy(rd_busy_n),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr),
        .busy_count(cnt_n), .a0(a0_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we0;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic        we1;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic        al;
        logic [4:0]  aa;
        logic [4:0]  r0;
        logic [4:0]  r1;
        logic [31:0] e_rd0_b;
        logic [31:0] e_rd0_n;
        logic [31:0] e_rd1;
        logic [1:0]  e_bsy_b;
        logic [1:0]  e_bsy_n;
        logic [5:0]  e_cnt;
        logic [31:0] e_a0;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        we0 = 0; waddr0 = 0; wdata0 = 0;
        we1 = 0; waddr1 = 0; wdata1 = 0;
        alloc_en = 0; alloc_addr = 0;
    endtask

    task automatic chk_outs(input string tag, input logic [31:0] e_rd0,
                            input logic [31:0] e_rd1, input logic [5:0] e_cnt,
                            input logic [31:0] e_a0);
        chk({tag, ".rd0_b"}, rd_data_b[31:0], e_rd0);
        chk({tag, ".rd0_n"}, rd_data_n[31:0], e_rd0);
        chk({tag, ".rd1_b"}, rd_data_b[63:32], e_rd1);
        chk({tag, ".busy_b"}, {30'd0, rd_busy_b}, 32'd0);
        chk({tag, ".busy_n"}, {30'd0, rd_busy_n}, 32'd0);
        chk({tag, ".cnt_b"}, {26'd0, cnt_b}, {26'd0, e_cnt});
        chk({tag, ".cnt_n"}, {26'd0, cnt_n}, {26'd0, e_cnt});
        chk({tag, ".a0_b"}, a0_b, e_a0);
        chk({tag, ".a0_n"}, a0_n, e_a0);
    endtask

    initial begin
        // we0 wa0 wd0 we1 wa1 wd1 al aa r0 r1 | rd0_b rd0_n rd1 bsy_b bsy_n cnt a0
        vecs[0]  = '{1, 3, 32'hDEADBEEF, 0, 0, 0, 0, 0, 3, 0,
                     32'hDEADBEEF, 0, 0, 2'b00, 2'b00, 0, 0};
        vecs[1]  = '{1, 7, 32'h11111111, 1, 7, 32'h22222222, 0, 0, 7, 3,
                     32'h22222222, 0, 32'hDEADBEEF, 2'b00, 2'b00, 0, 0};
        vecs[2]  = '{0, 0, 0, 0, 0, 0, 0, 0, 7, 3,
                     32'h22222222, 32'h22222222, 32'hDEADBEEF, 2'b00, 2'b00, 0, 0};
        vecs[3]  = '{0, 0, 0, 1, 0, 32'h55, 1, 0, 0, 0,
                     0, 0, 0, 2'b00, 2'b00, 0, 0};
        vecs[4]  = '{0, 0, 0, 0, 0, 0, 1, 10, 10, 0,
                     0, 0, 0, 2'b00, 2'b00, 0, 0};
        vecs[5]  = '{0, 0, 0, 0, 0, 0, 1, 5, 10, 5,
                     0, 0, 0, 2'b01, 2'b01, 1, 0};
        vecs[6]  = '{1, 10, 32'h42, 0, 0, 0, 0, 0, 10, 5,
                     32'h42, 0, 0, 2'b10, 2'b11, 2, 0};
        vecs[7]  = '{0, 0, 0, 0, 0, 0, 0, 0, 10, 5,
                     32'h42, 32'h42, 0, 2'b10, 2'b10, 1, 32'h42};
        vecs[8]  = '{0, 0, 0, 1, 10, 32'h99, 1, 10, 10, 5,
                     32'h99, 32'h42, 0, 2'b10, 2'b10, 1, 32'h42};
        vecs[9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 10, 5,
                     32'h99, 32'h99, 0, 2'b11, 2'b11, 2, 32'h99};
        vecs[10] = '{1, 5, 32'h77, 0, 0, 0, 1, 10, 5, 10,
                     32'h77, 0, 32'h99, 2'b10, 2'b11, 2, 32'h99};
        vecs[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 5, 10,
                     32'h77, 32'h77, 32'h99, 2'b10, 2'b10, 1, 32'h99};
        vecs[12] = '{0, 0, 0, 1, 3, 32'hCAFE0000, 0, 0, 3, 5,
                     32'hCAFE0000, 32'hDEADBEEF, 32'h77, 2'b00, 2'b00, 1, 32'h99};
        vecs[13] = '{0, 0, 0, 0, 0, 0, 0, 0, 3, 7,
                     32'hCAFE0000, 32'hCAFE0000, 32'h22222222, 2'b00, 2'b00, 1, 32'h99};

        // Held reset: write, alloc and bypass must all be suppressed.
        reset = 1'b0;
        idle();
        we0 = 1; waddr0 = 5; wdata0 = 32'hFFFFFFFF;
        alloc_en = 1; alloc_addr = 5;
        rd_addr = {5'd5, 5'd5};
        @(negedge clk);
        chk_outs("rst_hold", 0, 0, 0, 0);
        @(posedge clk); #1;
        chk("rst_edge.cnt_b", {26'd0, cnt_b}, 0);
        reset = 1'b1;
        idle();
        @(negedge clk);
        chk_outs("rst_rel", 0, 0, 0, 0);
        @(posedge clk); #1;

        for (int i = 0; i < 14; i++) begin
            we0 = vecs[i].we0; waddr0 = vecs[i].wa0; wdata0 = vecs[i].wd0;
            we1 = vecs[i].we1; waddr1 = vecs[i].wa1; wdata1 = vecs[i].wd1;
            alloc_en = vecs[i].al; alloc_addr = vecs[i].aa;
            rd_addr = {vecs[i].r1, vecs[i].r0};
            @(negedge clk);
            chk($sformatf("v%0d.rd0_b", i), rd_data_b[31:0], vecs[i].e_rd0_b);
            chk($sformatf("v%0d.rd0_n", i), rd_data_n[31:0], vecs[i].e_rd0_n);
            chk($sformatf("v%0d.rd1_b", i), rd_data_b[63:32], vecs[i].e_rd1);
            chk($sformatf("v%0d.rd1_n", i), rd_data_n[63:32], vecs[i].e_rd1);
            chk($sformatf("v%0d.busy_b", i), {30'd0, rd_busy_b}, {30'd0, vecs[i].e_bsy_b});
            chk($sformatf("v%0d.busy_n", i), {30'd0, rd_busy_n}, {30'd0, vecs[i].e_bsy_n});
            chk($sformatf("v%0d.cnt_b", i), {26'd0, cnt_b}, {26'd0, vecs[i].e_cnt});
            chk($sformatf("v%0d.cnt_n", i), {26'd0, cnt_n}, {26'd0, vecs[i].e_cnt});
            chk($sformatf("v%0d.a0_b", i), a0_b, vecs[i].e_a0);
            chk($sformatf("v%0d.a0_n", i), a0_n, vecs[i].e_a0);
            @(posedge clk); #1;
        end

        // Build up three busy registers (x10 already busy).
        idle();
        alloc_en = 1; alloc_addr = 3;
        @(posedge clk); #1;
        alloc_addr = 7;
        @(posedge clk); #1;
        idle();
        rd_addr = {5'd10, 5'd3};
        @(negedge clk);
        chk("pre_rst.cnt_b", {26'd0, cnt_b}, 3);
        chk("pre_rst.busy_b", {30'd0, rd_busy_b}, 32'd3);
        chk("pre_rst.a0_b", a0_b, 32'h99);
        chk("pre_rst.rd0_b", rd_data_b[31:0], 32'hCAFE0000);

        // Asynchronous reset between edges, with a bypassing write active.
        #2;
        we1 = 1; waddr1 = 3; wdata1 = 32'h123;
        reset = 1'b0;
        #1;
        chk_outs("async_rst", 0, 0, 0, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        idle();
        rd_addr = {5'd10, 5'd3};
        @(negedge clk);
        chk_outs("post_rst", 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
